// File: rtl/ethernet_tx_arbiter.sv
// ethernet_tx_arbiter: frame-atomic two-source arbiter in front of the 10G MAC
// transmit AXI-Stream. Owns the stream for a whole frame, inserts an idle gap
// after each frame, aborts a frame whose source stalls, counts frames/aborts.
// Optional feature macro: ETH_TX_ARB_RR_EN (round-robin tie-break; fixed
// priority to source 0 when undefined).
//
// Handshake: every stream follows AXI-Stream valid/ready -- a beat transfers on
// a cycle where tvalid and tready are both high; a presented beat is held
// unchanged by its source until it transfers.
module ethernet_tx_arbiter #(
  parameter int IFG_CYCLES    = 2,
  parameter int STALL_TIMEOUT = 1024
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        s0_axis_tvalid,
  input  logic [63:0] s0_axis_tdata,
  input  logic        s0_axis_tlast,
  input  logic [7:0]  s0_axis_tkeep,
  output logic        s0_axis_tready,
  input  logic        s1_axis_tvalid,
  input  logic [63:0] s1_axis_tdata,
  input  logic        s1_axis_tlast,
  input  logic [7:0]  s1_axis_tkeep,
  output logic        s1_axis_tready,
  output logic        tx_axis_tvalid,
  output logic [63:0] tx_axis_tdata,
  output logic        tx_axis_tlast,
  output logic [7:0]  tx_axis_tkeep,
  input  logic        tx_axis_tready,
  output logic [1:0]  o_grant,
  output logic        o_abort,
  output logic [15:0] o_frames0,
  output logic [15:0] o_frames1,
  output logic [7:0]  o_aborts,
  output logic [1:0]  o_dbg_state
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PASS = 2'd1,
    ST_GAP  = 2'd2
  } state_t;

  // Watchdog fires on the STALL_TIMEOUT-th consecutive non-accepting cycle.
  localparam logic [15:0] WD_LAST  = 16'(STALL_TIMEOUT - 1);
  localparam bit          IFG_ZERO = (IFG_CYCLES == 0);
  localparam logic [7:0]  GAP_LAST = IFG_ZERO ? 8'd0 : 8'(IFG_CYCLES - 1);

  state_t      r_state;
  state_t      w_next_state;
  logic [1:0]  r_grant;
  logic [15:0] r_wd;
  logic [7:0]  r_gap;
  logic [15:0] r_frames0;
  logic [15:0] r_frames1;
  logic [7:0]  r_aborts;
  logic [1:0]  w_win;
  logic        w_src_valid;
  logic [63:0] w_src_data;
  logic        w_src_last;
  logic [7:0]  w_src_keep;
  logic        w_accept;
  logic        w_stall;

`ifdef ETH_TX_ARB_RR_EN
  // Last-served source: 1 means source 1 was served most recently.
  logic r_last;
`endif

  // Next-state, arbitration and the combinational PASS data path.
  always_comb begin
    w_next_state   = r_state;
    w_win          = 2'b00;
    w_src_valid    = 1'b0;
    w_src_data     = '0;
    w_src_last     = 1'b0;
    w_src_keep     = '0;
    w_accept       = 1'b0;
    w_stall        = 1'b0;
    s0_axis_tready = 1'b0;
    s1_axis_tready = 1'b0;
    tx_axis_tvalid = 1'b0;
    tx_axis_tdata  = '0;
    tx_axis_tlast  = 1'b0;
    tx_axis_tkeep  = '0;
    case (r_state)
      ST_IDLE: begin
        if (s0_axis_tvalid || s1_axis_tvalid) begin
`ifdef ETH_TX_ARB_RR_EN
          if (s0_axis_tvalid && s1_axis_tvalid)
            w_win = r_last ? 2'b01 : 2'b10;
          else
            w_win = s0_axis_tvalid ? 2'b01 : 2'b10;
`else
          w_win = s0_axis_tvalid ? 2'b01 : 2'b10;
`endif
          w_next_state = ST_PASS;
        end
      end
      ST_PASS: begin
        if (r_grant[1]) begin
          w_src_valid = s1_axis_tvalid;
          w_src_data  = s1_axis_tdata;
          w_src_last  = s1_axis_tlast;
          w_src_keep  = s1_axis_tkeep;
        end else begin
          w_src_valid = s0_axis_tvalid;
          w_src_data  = s0_axis_tdata;
          w_src_last  = s0_axis_tlast;
          w_src_keep  = s0_axis_tkeep;
        end
        // Stall is judged on the raw source handshake so that silencing the
        // outputs in the abort cycle cannot feed back into the decision.
        w_stall = (r_wd == WD_LAST) && !(w_src_valid && tx_axis_tready);
        if (!w_stall) begin
          tx_axis_tvalid = w_src_valid;
          tx_axis_tdata  = w_src_data;
          tx_axis_tlast  = w_src_last;
          tx_axis_tkeep  = w_src_keep;
          s0_axis_tready = r_grant[0] & tx_axis_tready;
          s1_axis_tready = r_grant[1] & tx_axis_tready;
        end
        w_accept = !w_stall && w_src_valid && tx_axis_tready;
        if ((w_accept && w_src_last) || w_stall)
          w_next_state = IFG_ZERO ? ST_IDLE : ST_GAP;
      end
      ST_GAP: begin
        if (r_gap == GAP_LAST) w_next_state = ST_IDLE;
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  // State register, grant, watchdog, gap timer and statistics counters.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state   <= ST_IDLE;
      r_grant   <= 2'b00;
      r_wd      <= '0;
      r_gap     <= '0;
      r_frames0 <= '0;
      r_frames1 <= '0;
      r_aborts  <= '0;
    end else begin
      r_state <= w_next_state;
      case (r_state)
        ST_IDLE: begin
          r_grant <= w_win;
          r_wd    <= '0;
          r_gap   <= '0;
        end
        ST_PASS: begin
          r_gap <= '0;
          if (w_next_state != ST_PASS) r_grant <= 2'b00;
          if (w_accept) r_wd <= '0;
          else          r_wd <= r_wd + 16'd1;
          if (w_accept && w_src_last) begin
            if (r_grant[0]) r_frames0 <= r_frames0 + 16'd1;
            if (r_grant[1]) r_frames1 <= r_frames1 + 16'd1;
          end
          if (w_stall && (r_aborts != 8'hFF)) r_aborts <= r_aborts + 8'd1;
        end
        ST_GAP: r_gap <= r_gap + 8'd1;
        default: r_grant <= 2'b00;
      endcase
    end
  end

`ifdef ETH_TX_ARB_RR_EN
  // Remember which source completed the most recent frame (aborts excluded).
  always_ff @(posedge i_clk) begin
    if (i_reset) r_last <= 1'b1;
    else if ((r_state == ST_PASS) && w_accept && w_src_last) r_last <= r_grant[1];
  end
`endif

  assign o_grant     = r_grant;
  assign o_abort     = w_stall;
  assign o_frames0   = r_frames0;
  assign o_frames1   = r_frames1;
  assign o_aborts    = r_aborts;
  assign o_dbg_state = r_state;

endmodule
